// File: rtl/ps2_oric_matrix.sv
// ps2_oric_matrix
// Turns hps_io PS/2 key events into the Oric/Telestrat 8x8 keyboard matrix.
// The VIA row scan and PSG column mask are answered with a registered sense
// bit. F12 and Ctrl+Alt+Del are also decoded into one-cycle request pulses.
//
// Ports
//   clk_sys    system clock
//   RESET      synchronous, active-high reset
//   ps2_key    [10] strobe toggle, [9] pressed, [8] extended, [7:0] scancode
//   row_sel    VIA PB[2:0] row select
//   col_mask   PSG port A; a 0 bit enables that column
//   key_sense  VIA PB3; pressed key in selected row and an enabled column
//   nmi_req    one-cycle pulse on F12 make
//   reset_req  one-cycle pulse on Ctrl+Alt+Del make (Del = extended 0x71)
//   keys_down  number of matrix positions currently set (0..64)
//
// Pipeline: event -> s1 latch -> s2 lookup/modifiers -> s3 matrix write/pulses.
// The pipeline takes one event per cycle and never stalls.
module ps2_oric_matrix #(
  parameter KEYMAP_FILE = "oric_keymap.vh"
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic [10:0] ps2_key,
  input  logic [2:0]  row_sel,
  input  logic [7:0]  col_mask,
  output logic        key_sense,
  output logic        nmi_req,
  output logic        reset_req,
  output logic [6:0]  keys_down
);

  // The lookup below is the built-in Oric layout. It serves as the table
  // that KEYMAP_FILE names, so the parameter only documents the source.
  localparam bit KEYMAP_SET = (KEYMAP_FILE != "");

  // {valid, row[2:0], col[2:0]}
  function automatic logic [6:0] keymap(input logic ext, input logic [7:0] code);
    keymap = 7'd0;
    if (ext) begin
      case (code)
        8'h75: keymap = {1'b1, 3'd6, 3'd2};  // up
        8'h72: keymap = {1'b1, 3'd6, 3'd3};  // down
        8'h6B: keymap = {1'b1, 3'd6, 3'd4};  // left
        8'h74: keymap = {1'b1, 3'd6, 3'd6};  // right
        default: ;
      endcase
    end else begin
      case (code)
        8'h29: keymap = {1'b1, 3'd0, 3'd0};  // space
        8'h16: keymap = {1'b1, 3'd0, 3'd1};  // 1
        8'h1E: keymap = {1'b1, 3'd0, 3'd2};  // 2
        8'h26: keymap = {1'b1, 3'd0, 3'd3};  // 3
        8'h25: keymap = {1'b1, 3'd0, 3'd4};  // 4
        8'h2E: keymap = {1'b1, 3'd0, 3'd5};  // 5
        8'h36: keymap = {1'b1, 3'd0, 3'd6};  // 6
        8'h3D: keymap = {1'b1, 3'd0, 3'd7};  // 7
        8'h3E: keymap = {1'b1, 3'd1, 3'd0};  // 8
        8'h46: keymap = {1'b1, 3'd1, 3'd1};  // 9
        8'h45: keymap = {1'b1, 3'd1, 3'd2};  // 0
        8'h15: keymap = {1'b1, 3'd1, 3'd3};  // Q
        8'h1D: keymap = {1'b1, 3'd1, 3'd4};  // W
        8'h24: keymap = {1'b1, 3'd1, 3'd5};  // E
        8'h2D: keymap = {1'b1, 3'd1, 3'd6};  // R
        8'h2C: keymap = {1'b1, 3'd1, 3'd7};  // T
        8'h35: keymap = {1'b1, 3'd2, 3'd0};  // Y
        8'h3C: keymap = {1'b1, 3'd2, 3'd1};  // U
        8'h43: keymap = {1'b1, 3'd2, 3'd2};  // I
        8'h44: keymap = {1'b1, 3'd2, 3'd3};  // O
        8'h14: keymap = {1'b1, 3'd2, 3'd4};  // ctrl
        8'h4D: keymap = {1'b1, 3'd2, 3'd5};  // P
        8'h1B: keymap = {1'b1, 3'd2, 3'd6};  // S
        8'h23: keymap = {1'b1, 3'd2, 3'd7};  // D
        8'h2B: keymap = {1'b1, 3'd3, 3'd0};  // F
        8'h34: keymap = {1'b1, 3'd3, 3'd1};  // G
        8'h33: keymap = {1'b1, 3'd3, 3'd2};  // H
        8'h3B: keymap = {1'b1, 3'd3, 3'd3};  // J
        8'h42: keymap = {1'b1, 3'd3, 3'd4};  // K
        8'h4B: keymap = {1'b1, 3'd3, 3'd5};  // L
        8'h1A: keymap = {1'b1, 3'd3, 3'd6};  // Z
        8'h22: keymap = {1'b1, 3'd3, 3'd7};  // X
        8'h21: keymap = {1'b1, 3'd4, 3'd0};  // C
        8'h2A: keymap = {1'b1, 3'd4, 3'd1};  // V
        8'h32: keymap = {1'b1, 3'd4, 3'd2};  // B
        8'h31: keymap = {1'b1, 3'd4, 3'd3};  // N
        8'h12: keymap = {1'b1, 3'd4, 3'd4};  // left shift
        8'h3A: keymap = {1'b1, 3'd4, 3'd5};  // M
        8'h41: keymap = {1'b1, 3'd4, 3'd6};  // ,
        8'h49: keymap = {1'b1, 3'd4, 3'd7};  // .
        8'h76: keymap = {1'b1, 3'd5, 3'd0};  // esc
        8'h66: keymap = {1'b1, 3'd5, 3'd1};  // backspace -> DEL
        8'h4E: keymap = {1'b1, 3'd5, 3'd2};  // -
        8'h55: keymap = {1'b1, 3'd5, 3'd3};  // =
        8'h4C: keymap = {1'b1, 3'd5, 3'd4};  // ;
        8'h52: keymap = {1'b1, 3'd5, 3'd5};  // '
        8'h4A: keymap = {1'b1, 3'd5, 3'd6};  // /
        8'h5D: keymap = {1'b1, 3'd5, 3'd7};  // backslash
        8'h54: keymap = {1'b1, 3'd6, 3'd0};  // [
        8'h5B: keymap = {1'b1, 3'd6, 3'd1};  // ]
        8'h1C: keymap = {1'b1, 3'd6, 3'd5};  // A
        8'h0D: keymap = {1'b1, 3'd6, 3'd7};  // tab -> FUNCT
        8'h59: keymap = {1'b1, 3'd7, 3'd4};  // right shift
        8'h5A: keymap = {1'b1, 3'd7, 3'd5};  // enter
        default: ;
      endcase
    end
  endfunction

  logic              stb_q;
  logic              v1, v2;
  logic              pr1, ext1;
  logic [7:0]        code1;
  logic              hit2, pr2, nmi2, rst2;
  logic [2:0]        row2, col2;
  logic              ctrl_dn, alt_dn, shift;
  logic [7:0][7:0]   matrix;
  logic [6:0]        lk;

  assign lk = keymap(ext1, code1);

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      // Track the live strobe so the first cycle after reset sees no event
      stb_q     <= ps2_key[10];
      v1        <= 1'b0;
      v2        <= 1'b0;
      pr1       <= 1'b0;
      ext1      <= 1'b0;
      code1     <= 8'd0;
      hit2      <= 1'b0;
      pr2       <= 1'b0;
      nmi2      <= 1'b0;
      rst2      <= 1'b0;
      row2      <= 3'd0;
      col2      <= 3'd0;
      ctrl_dn   <= 1'b0;
      alt_dn    <= 1'b0;
      shift     <= 1'b0;
      matrix    <= '0;
      keys_down <= 7'd0;
      key_sense <= 1'b0;
      nmi_req   <= 1'b0;
      reset_req <= 1'b0;
    end else begin
      // stage 1: strobe edge latches the event
      stb_q <= ps2_key[10];
      v1    <= ps2_key[10] != stb_q;
      pr1   <= ps2_key[9];
      ext1  <= ps2_key[8];
      code1 <= ps2_key[7:0];

      // stage 2: lookup and modifier tracking. The reset hot-key uses the
      // modifier state before this event; the event is Del, so it never
      // changes the modifiers itself.
      v2   <= v1;
      hit2 <= lk[6];
      row2 <= lk[5:3];
      col2 <= lk[2:0];
      pr2  <= pr1;
      nmi2 <= pr1 & ~ext1 & (code1 == 8'h07);
      rst2 <= pr1 & ext1 & (code1 == 8'h71) & ctrl_dn & alt_dn;
      if (v1) begin
        if (code1 == 8'h14) ctrl_dn <= pr1;
        if (code1 == 8'h11) alt_dn  <= pr1;
        if (!ext1 && (code1 == 8'h12 || code1 == 8'h59)) shift <= pr1;
      end

      // stage 3: matrix write; the count moves only on real bit transitions
      nmi_req   <= v2 & nmi2;
      reset_req <= v2 & rst2;
      if (v2 && hit2) begin
        matrix[row2][col2] <= pr2;
        if (pr2 && !matrix[row2][col2])
          keys_down <= keys_down + 7'd1;
        else if (!pr2 && matrix[row2][col2])
          keys_down <= keys_down - 7'd1;
      end

      key_sense <= |(matrix[row_sel] & ~col_mask);
    end
  end

  // Shift is tracked for the host side but has no consumer in this block
  wire unused_ok = &{1'b0, shift, KEYMAP_SET};

endmodule

// File: tb/tb_ps2_oric_matrix.sv
module tb_ps2_oric_matrix;

  logic        clk_sys = 1'b0;
  logic        RESET;
  logic [10:0] ps2_key;
  logic [2:0]  row_sel;
  logic [7:0]  col_mask;
  logic        key_sense, nmi_req, reset_req;
  logic [6:0]  keys_down;

  int checks = 0;
  int errors = 0;

  ps2_oric_matrix dut (
    .clk_sys   (clk_sys),
    .RESET     (RESET),
    .ps2_key   (ps2_key),
    .row_sel   (row_sel),
    .col_mask  (col_mask),
    .key_sense (key_sense),
    .nmi_req   (nmi_req),
    .reset_req (reset_req),
    .keys_down (keys_down)
  );

  always #5 clk_sys = ~clk_sys;

  // Toggle the strobe on a falling edge; the next rising edge is stage 1.
  task automatic send(input logic pr, input logic ex, input logic [7:0] code);
    @(negedge clk_sys);
    ps2_key = {~ps2_key[10], pr, ex, code};
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    repeat (3) @(negedge clk_sys);
    RESET = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (keys_down !== 7'd0) begin errors++; $display("FAIL rst_keys: got %0d want 0", keys_down); end
    checks++;
    if (key_sense !== 1'b0) begin errors++; $display("FAIL rst_sense: got %b want 0", key_sense); end
    checks++;
    if (nmi_req !== 1'b0) begin errors++; $display("FAIL rst_nmi: got %b want 0", nmi_req); end
    checks++;
    if (reset_req !== 1'b0) begin errors++; $display("FAIL rst_rreq: got %b want 0", reset_req); end
  endtask

  task automatic test_press_release;
    row_sel = 3'd6; col_mask = 8'hDF;
    send(1'b1, 1'b0, 8'h1C);
    repeat (3) @(negedge clk_sys);
    checks++;
    if (keys_down !== 7'd1) begin errors++; $display("FAIL pr_keys: got %0d want 1", keys_down); end
    checks++;
    if (key_sense !== 1'b0) begin errors++; $display("FAIL pr_sense_early: got %b want 0", key_sense); end
    @(negedge clk_sys);
    checks++;
    if (key_sense !== 1'b1) begin errors++; $display("FAIL pr_sense: got %b want 1", key_sense); end
    send(1'b0, 1'b0, 8'h1C);
    repeat (3) @(negedge clk_sys);
    checks++;
    if (keys_down !== 7'd0) begin errors++; $display("FAIL rel_keys: got %0d want 0", keys_down); end
    @(negedge clk_sys);
    checks++;
    if (key_sense !== 1'b0) begin errors++; $display("FAIL rel_sense: got %b want 0", key_sense); end
  endtask

  task automatic test_typematic;
    row_sel = 3'd6; col_mask = 8'hDF;
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 1'b0, 8'h1C);
      repeat (4) @(negedge clk_sys);
    end
    checks++;
    if (keys_down !== 7'd1) begin errors++; $display("FAIL typ_keys: got %0d want 1", keys_down); end
    send(1'b0, 1'b0, 8'h29);  // release of unpressed space
    repeat (4) @(negedge clk_sys);
    checks++;
    if (keys_down !== 7'd1) begin errors++; $display("FAIL unp_rel_keys: got %0d want 1", keys_down); end
    col_mask = 8'hFF;
    @(negedge clk_sys);
    checks++;
    if (key_sense !== 1'b0) begin errors++; $display("FAIL mask_ff: got %b want 0", key_sense); end
    col_mask = 8'hDF;
    @(negedge clk_sys);
    checks++;
    if (key_sense !== 1'b1) begin errors++; $display("FAIL mask_df: got %b want 1", key_sense); end
    send(1'b0, 1'b0, 8'h1C);
    repeat (4) @(negedge clk_sys);
    checks++;
    if (keys_down !== 7'd0) begin errors++; $display("FAIL typ_rel: got %0d want 0", keys_down); end
  endtask

  task automatic test_reset_hotkey;
    int pulses;
    send(1'b1, 1'b0, 8'h14);  // ctrl (also a matrix key)
    send(1'b1, 1'b0, 8'h11);  // alt (not in matrix)
    repeat (4) @(negedge clk_sys);
    checks++;
    if (keys_down !== 7'd1) begin errors++; $display("FAIL ctrl_keys: got %0d want 1", keys_down); end
    send(1'b1, 1'b1, 8'h71);
    repeat (2) @(negedge clk_sys);
    checks++;
    if (reset_req !== 1'b0) begin errors++; $display("FAIL rreq_n2: got %b want 0", reset_req); end
    @(negedge clk_sys);
    checks++;
    if (reset_req !== 1'b1) begin errors++; $display("FAIL rreq_n3: got %b want 1", reset_req); end
    @(negedge clk_sys);
    checks++;
    if (reset_req !== 1'b0) begin errors++; $display("FAIL rreq_n4: got %b want 0", reset_req); end
    send(1'b0, 1'b1, 8'h71);
    send(1'b0, 1'b0, 8'h14);
    send(1'b0, 1'b0, 8'h11);
    repeat (4) @(negedge clk_sys);
    checks++;
    if (keys_down !== 7'd0) begin errors++; $display("FAIL mod_rel_keys: got %0d want 0", keys_down); end
    send(1'b1, 1'b1, 8'h71);  // Del alone
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys);
      if (reset_req) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL del_alone: got %0d pulses want 0", pulses); end
    send(1'b0, 1'b1, 8'h71);
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic test_nmi;
    int pulses;
    send(1'b1, 1'b0, 8'h07);
    repeat (3) @(negedge clk_sys);
    checks++;
    if (nmi_req !== 1'b1) begin errors++; $display("FAIL nmi_n3: got %b want 1", nmi_req); end
    @(negedge clk_sys);
    checks++;
    if (nmi_req !== 1'b0) begin errors++; $display("FAIL nmi_n4: got %b want 0", nmi_req); end
    checks++;
    if (keys_down !== 7'd0) begin errors++; $display("FAIL nmi_keys: got %0d want 0", keys_down); end
    send(1'b0, 1'b0, 8'h07);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys);
      if (nmi_req) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL nmi_break: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_back_to_back;
    row_sel = 3'd7; col_mask = 8'hDF;
    send(1'b1, 1'b0, 8'h29);  // space
    send(1'b1, 1'b0, 8'h5A);  // enter, next cycle
    repeat (2) @(negedge clk_sys);
    checks++;
    if (keys_down !== 7'd1) begin errors++; $display("FAIL b2b_first: got %0d want 1", keys_down); end
    @(negedge clk_sys);
    checks++;
    if (keys_down !== 7'd2) begin errors++; $display("FAIL b2b_keys: got %0d want 2", keys_down); end
    @(negedge clk_sys);
    checks++;
    if (key_sense !== 1'b1) begin errors++; $display("FAIL b2b_enter: got %b want 1", key_sense); end
    row_sel = 3'd0; col_mask = 8'hFE;
    @(negedge clk_sys);
    checks++;
    if (key_sense !== 1'b1) begin errors++; $display("FAIL b2b_space: got %b want 1", key_sense); end
    col_mask = 8'hFD;
    @(negedge clk_sys);
    checks++;
    if (key_sense !== 1'b0) begin errors++; $display("FAIL b2b_col1: got %b want 0", key_sense); end
    send(1'b0, 1'b0, 8'h29);
    send(1'b0, 1'b0, 8'h5A);
    repeat (4) @(negedge clk_sys);
    checks++;
    if (keys_down !== 7'd0) begin errors++; $display("FAIL b2b_rel: got %0d want 0", keys_down); end
  endtask

  task automatic test_reset_midpipe;
    row_sel = 3'd6; col_mask = 8'hDF;
    send(1'b1, 1'b0, 8'h1C);        // A enters stage 1 on the next edge
    send(1'b1, 1'b0, 8'h29);        // second event pending
    RESET = 1'b1;
    @(negedge clk_sys);
    RESET = 1'b0;
    repeat (6) @(negedge clk_sys);
    checks++;
    if (keys_down !== 7'd0) begin errors++; $display("FAIL mid_keys: got %0d want 0", keys_down); end
    checks++;
    if (key_sense !== 1'b0) begin errors++; $display("FAIL mid_sense: got %b want 0", key_sense); end
    checks++;
    if ({nmi_req, reset_req} !== 2'b00) begin errors++; $display("FAIL mid_pulses: got %b want 00", {nmi_req, reset_req}); end
    row_sel = 3'd0; col_mask = 8'hFE;
    @(negedge clk_sys);
    checks++;
    if (key_sense !== 1'b0) begin errors++; $display("FAIL mid_space: got %b want 0", key_sense); end
  endtask

  initial begin
    RESET    = 1'b1;
    ps2_key  = 11'd0;
    row_sel  = 3'd0;
    col_mask = 8'hFF;
    test_reset();
    test_press_release();
    test_typematic();
    test_reset_hotkey();
    test_nmi();
    test_back_to_back();
    test_reset_midpipe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
